// File: rtl/alu_pkg.sv
// Shared opcode map, FSM states, flag payloads and the opcode class decoder.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NAND  = 4'd6,
    OP_NOR   = 4'd7,
    OP_XOR   = 4'd8,
    OP_XNOR  = 4'd9,
    OP_CMPEQ = 4'd10,
    OP_CMPGT = 4'd11,
    OP_CMPLT = 4'd12,
    OP_SHR   = 4'd13,
    OP_SHL   = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // One-hot class of the completed operation (all zero for the reserved opcode)
  typedef struct packed {
    logic arith;
    logic logical;
    logic cmp;
    logic shift;
  } alu_class_t;

  // Status payload registered alongside the result
  typedef struct packed {
    alu_class_t cls;
    logic       carry;
    logic       ovf;
    logic       dz;
    logic       bad_op;
  } alu_flags_t;

  // Status reported for a division that ran through the iterative divider
  localparam alu_flags_t DIV_FLAGS = '{
    cls:    '{arith: 1'b1, logical: 1'b0, cmp: 1'b0, shift: 1'b0},
    carry:  1'b0,
    ovf:    1'b0,
    dz:     1'b0,
    bad_op: 1'b0
  };

  // Map an opcode to its class flags
  function automatic alu_class_t op_class(alu_op_e op);
    alu_class_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV:                   c.arith   = 1'b1;
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:  c.logical = 1'b1;
      OP_CMPEQ, OP_CMPGT, OP_CMPLT:                     c.cmp     = 1'b1;
      OP_SHR, OP_SHL:                                   c.shift   = 1'b1;
      default:                                          c         = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_iter_div.sv
// Restoring divider: one quotient bit per clock, WIDTH iterations, first one on the start edge.
module alu_iter_div
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] s_rem, s_quo, s_dvs;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] nrem_c, nquo_c;
  logic             qbit_c;

  // One shift-subtract step; on start it works directly on the incoming operands
  always_comb begin
    s_rem   = start_i ? '0 : rem_q;
    s_quo   = start_i ? dividend_i : quo_q;
    s_dvs   = start_i ? divisor_i : dvs_q;
    trial_c = {s_rem, s_quo[WIDTH-1]};
    qbit_c  = (trial_c >= {1'b0, s_dvs});
    nrem_c  = qbit_c ? WIDTH'(trial_c - {1'b0, s_dvs}) : trial_c[WIDTH-1:0];
    nquo_c  = {s_quo[WIDTH-2:0], qbit_c};
  end

  // Iteration control: load on start, step while busy, pulse done after the last bit
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = nrem_c;
      quo_d  = nquo_c;
      dvs_d  = divisor_i;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = nrem_c;
      quo_d = nquo_c;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/alu_pipe_hs.sv
// Handshaked ALU: valid/ready on both sides, single-cycle ops, iterative divide.
module alu_pipe_hs
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             arith_flag,
  output logic             logic_flag,
  output logic             cmp_flag,
  output logic             shift_flag,
  output logic             carry,
  output logic             ovf,
  output logic             dz,
  output logic             bad_op
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  alu_state_e       state_q, state_d;
  alu_op_e          op_e;
  logic             accept_c, load_c, div_start_c, div_fin_c;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] res_c, result_q;
  alu_flags_t       flg_c, flags_q;
  logic             out_valid_q;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    prod_c;
  logic [SHW-1:0]   shamt_c;

  assign op_e     = alu_op_e'(op);
  assign in_ready = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready)) && !div_busy;
  assign accept_c = in_valid && in_ready;

  // Single-cycle datapath on the operands presented at acceptance
  always_comb begin
    res_c     = '0;
    flg_c     = '0;
    sum_c     = {1'b0, a} + {1'b0, b};
    prod_c    = PW'(a) * PW'(b);
    shamt_c   = b[SHW-1:0];
    flg_c.cls = op_class(op_e);
    case (op_e)
      OP_ADD: begin
        res_c       = sum_c[WIDTH-1:0];
        flg_c.carry = sum_c[WIDTH];
      end
      OP_SUB: begin
        res_c       = a - b;
        flg_c.carry = (a >= b);
      end
      OP_MUL: begin
        res_c     = prod_c[WIDTH-1:0];
        flg_c.ovf = |prod_c[PW-1:WIDTH];
      end
      // Only the divide-by-zero case is taken from here; real quotients come from the divider
      OP_DIV: begin
        res_c    = '1;
        flg_c.dz = 1'b1;
      end
      OP_AND:   res_c = a & b;
      OP_OR:    res_c = a | b;
      OP_NAND:  res_c = ~(a & b);
      OP_NOR:   res_c = ~(a | b);
      OP_XOR:   res_c = a ^ b;
      OP_XNOR:  res_c = ~(a ^ b);
      OP_CMPEQ: res_c = (a == b) ? WIDTH'(1) : '0;
      OP_CMPGT: res_c = (a > b)  ? WIDTH'(2) : '0;
      OP_CMPLT: res_c = (a < b)  ? WIDTH'(3) : '0;
      OP_SHR:   res_c = a >> shamt_c;
      OP_SHL:   res_c = a << shamt_c;
      default:  flg_c.bad_op = 1'b1;
    endcase
  end

  // Next-state and control: accept, launch divides, retire on out_ready
  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    div_start_c = 1'b0;
    div_fin_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
        if (accept_c) begin
          if ((op_e == OP_DIV) && (b != '0)) begin
            state_d     = ST_DIV;
            div_start_c = 1'b1;
          end else begin
            state_d = ST_DONE;
            load_c  = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d   = ST_DONE;
          div_fin_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: holds result and status until the consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= (state_d == ST_DONE);
      if (load_c) begin
        result_q <= res_c;
        flags_q  <= flg_c;
      end else if (div_fin_c) begin
        result_q <= div_quo;
        flags_q  <= DIV_FLAGS;
      end
    end
  end

  alu_iter_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start_c),
    .dividend_i(a),
    .divisor_i (b),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quotient_o(div_quo)
  );

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign arith_flag = flags_q.cls.arith;
  assign logic_flag = flags_q.cls.logical;
  assign cmp_flag   = flags_q.cls.cmp;
  assign shift_flag = flags_q.cls.shift;
  assign carry      = flags_q.carry;
  assign ovf        = flags_q.ovf;
  assign dz         = flags_q.dz;
  assign bad_op     = flags_q.bad_op;

endmodule
